// File: rtl/phy_prbs_link_test_ctrl_if.sv
// Control, status and PHY-facing signals of the PRBS31 link self-test sequencer.
// master = the sequencer, slave = the test host / PHY side.
interface phy_prbs_link_test_ctrl_if #(
    parameter int CNT_WIDTH = 32
);
    logic                 start;
    logic                 abort;
    logic                 rx_block_lock;
    logic                 rx_high_ber;
    logic [6:0]           rx_error_count;
    logic                 phy_rst;
    logic                 cfg_tx_prbs31_enable;
    logic                 cfg_rx_prbs31_enable;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic                 lock_timeout;
    logic                 high_ber_seen;
    logic [CNT_WIDTH-1:0] err_total;
    logic [CNT_WIDTH-1:0] block_total;

    modport master (
        input  start, abort, rx_block_lock, rx_high_ber, rx_error_count,
        output phy_rst, cfg_tx_prbs31_enable, cfg_rx_prbs31_enable, busy, done, pass,
               lock_timeout, high_ber_seen, err_total, block_total
    );

    modport slave (
        output start, abort, rx_block_lock, rx_high_ber, rx_error_count,
        input  phy_rst, cfg_tx_prbs31_enable, cfg_rx_prbs31_enable, busy, done, pass,
               lock_timeout, high_ber_seen, err_total, block_total
    );
endinterface

// File: rtl/phy_prbs_link_test_ctrl.sv
// PRBS31 link self-test sequencer for one eth_phy_10g: PHY reset, lock wait, settle, error count.
// Optional macro PHY_LINK_TEST_LOCK_MON_EN fails the test on any lock loss during SETTLE or RUN.
module phy_prbs_link_test_ctrl #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int SETTLE_CYCLES = 64,
    parameter int TEST_BLOCKS   = 100000,
    parameter int ERR_THRESH    = 0,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    phy_prbs_link_test_ctrl_if.master link
);
    typedef enum logic [2:0] {
        IDLE,
        RESET,
        WAIT_LOCK,
        SETTLE,
        RUN,
        DONE_PASS,
        DONE_FAIL
    } state_t;

    localparam logic [31:0] RST_LAST    = 32'(RST_CYCLES - 1);
    localparam logic [31:0] LOCK_LAST   = 32'(LOCK_TIMEOUT - 1);
    localparam logic [31:0] SETTLE_LAST = (SETTLE_CYCLES > 0) ? 32'(SETTLE_CYCLES - 1) : 32'd0;
    localparam logic [CNT_WIDTH-1:0] BLOCKS_END = CNT_WIDTH'(TEST_BLOCKS);
    localparam logic [CNT_WIDTH-1:0] THRESH     = CNT_WIDTH'(ERR_THRESH);

    state_t               state_q, state_d;
    logic [31:0]          timer_q, timer_d;
    logic [CNT_WIDTH-1:0] err_q, err_d, blk_q, blk_d;
    logic                 lto_q, lto_d, hb_q, hb_d;
    logic                 phy_rst_q, active_q, done_q, pass_q;
    logic [CNT_WIDTH:0]   err_sum;
    logic [CNT_WIDTH-1:0] err_sat, blk_inc;
    logic                 hb_run, lock_lost;

`ifdef PHY_LINK_TEST_LOCK_MON_EN
    assign lock_lost = !link.rx_block_lock;
`else
    assign lock_lost = 1'b0;
`endif

    // Next state and counter updates; abort overrides every other transition.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        err_d   = err_q;
        blk_d   = blk_q;
        lto_d   = lto_q;
        hb_d    = hb_q;
        err_sum = {1'b0, err_q} + (CNT_WIDTH + 1)'(link.rx_error_count);
        err_sat = err_sum[CNT_WIDTH] ? '1 : err_sum[CNT_WIDTH-1:0];
        blk_inc = blk_q + 1'b1;
        hb_run  = hb_q | link.rx_high_ber;
        if (link.abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE_PASS, DONE_FAIL: begin
                    if (link.start) begin
                        state_d = RESET;
                        timer_d = '0;
                        err_d   = '0;
                        blk_d   = '0;
                        lto_d   = 1'b0;
                        hb_d    = 1'b0;
                    end
                end
                RESET: begin
                    if (timer_q == RST_LAST) begin
                        state_d = WAIT_LOCK;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (link.rx_block_lock) begin
                        state_d = (SETTLE_CYCLES == 0) ? RUN : SETTLE;
                        timer_d = '0;
                    end else if (timer_q == LOCK_LAST) begin
                        state_d = DONE_FAIL;
                        lto_d   = 1'b1;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                SETTLE: begin
                    if (lock_lost) begin
                        state_d = DONE_FAIL;
                    end else if (timer_q == SETTLE_LAST) begin
                        state_d = RUN;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                RUN: begin
                    if (lock_lost) begin
                        state_d = DONE_FAIL;
                    end else begin
                        err_d = err_sat;
                        blk_d = blk_inc;
                        hb_d  = hb_run;
                        // The final block's errors and BER flag take part in the verdict.
                        if (blk_inc == BLOCKS_END) begin
                            state_d = (err_sat <= THRESH && !hb_run) ? DONE_PASS : DONE_FAIL;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they change together with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            err_q     <= '0;
            blk_q     <= '0;
            lto_q     <= 1'b0;
            hb_q      <= 1'b0;
            phy_rst_q <= 1'b0;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            err_q     <= err_d;
            blk_q     <= blk_d;
            lto_q     <= lto_d;
            hb_q      <= hb_d;
            phy_rst_q <= (state_d == RESET);
            active_q  <= (state_d inside {RESET, WAIT_LOCK, SETTLE, RUN});
            done_q    <= (state_d inside {DONE_PASS, DONE_FAIL});
            pass_q    <= (state_d == DONE_PASS);
        end
    end

    assign link.phy_rst              = phy_rst_q;
    assign link.cfg_tx_prbs31_enable = active_q;
    assign link.cfg_rx_prbs31_enable = active_q;
    assign link.busy                 = active_q;
    assign link.done                 = done_q;
    assign link.pass                 = pass_q;
    assign link.lock_timeout         = lto_q;
    assign link.high_ber_seen        = hb_q;
    assign link.err_total            = err_q;
    assign link.block_total          = blk_q;
endmodule

// File: tb/tb_phy_prbs_link_test_ctrl.sv
// Randomized self-checking bench for phy_prbs_link_test_ctrl against an edge-indexed outcome model.
// Honours PHY_LINK_TEST_LOCK_MON_EN the same way the design does.
module tb_phy_prbs_link_test_ctrl;
    localparam int R    = 4;
    localparam int T    = 24;
    localparam int S    = 2;
    localparam int B    = 10;
    localparam int THR  = 5;
    localparam int W    = 8;
    localparam int MAXE = 64;
    localparam int MAXV = (1 << W) - 1;

    logic clk_tb = 1'b0;
    logic rst_n_tb;

    phy_prbs_link_test_ctrl_if #(.CNT_WIDTH(W)) link ();

    phy_prbs_link_test_ctrl #(
        .RST_CYCLES(R), .LOCK_TIMEOUT(T), .SETTLE_CYCLES(S),
        .TEST_BLOCKS(B), .ERR_THRESH(THR), .CNT_WIDTH(W)
    ) dut (
        .clk(clk_tb),
        .rst_n(rst_n_tb),
        .link(link)
    );

    always #5 clk_tb = ~clk_tb;

    logic [7+2*W:0] outs;
    assign outs = {link.phy_rst, link.cfg_tx_prbs31_enable, link.cfg_rx_prbs31_enable, link.busy,
                   link.done, link.pass, link.lock_timeout, link.high_ber_seen,
                   link.err_total, link.block_total};

    int checks = 0;
    int errors = 0;

    // Stimulus indexed by clock edge, edge 0 being the one that samples start.
    bit       stim_lock [MAXE];
    bit [6:0] stim_err  [MAXE];
    bit       stim_ber  [MAXE];
    bit       use_noise;

    int obs_rst_cnt, obs_en_cnt, obs_done_edge;
    int m_done, m_err, m_blk;
    bit m_pass, m_lto, m_hb;

    task automatic fill_stim(input int lock_first, input int drop_edge, input int err_mode, input int ber_pct);
        for (int n = 0; n < MAXE; n++) begin
            stim_lock[n] = (lock_first >= 0) && (n >= lock_first) && (n != drop_edge);
            case (err_mode)
                1:       stim_err[n] = ($urandom_range(0, 4) == 0) ? 7'($urandom_range(1, 3)) : 7'd0;
                2:       stim_err[n] = 7'd127;
                default: stim_err[n] = 7'd0;
            endcase
            stim_ber[n] = ($urandom_range(0, 99) < ber_pct);
        end
    endtask

    // Reset occupies edges 0..R-1, lock is looked for on edges R+1..R+T, then S settle edges and B run edges.
    task automatic model_outcome();
        int n0;
        int acc;
        n0 = -1;
        m_err = 0; m_blk = 0; m_pass = 0; m_lto = 0; m_hb = 0;
        for (int n = R + 1; n <= R + T; n++) if (stim_lock[n] && n0 < 0) n0 = n;
        if (n0 < 0) begin
            m_done = R + T;
            m_lto  = 1;
            return;
        end
        m_done = n0 + S + B;
        for (int n = n0 + 1; n <= n0 + S + B; n++) begin
`ifdef PHY_LINK_TEST_LOCK_MON_EN
            if (!stim_lock[n]) begin
                m_done = n;
                return;
            end
`endif
            if (n > n0 + S) begin
                m_blk++;
                acc   = m_err + int'(stim_err[n]);
                m_err = (acc > MAXV) ? MAXV : acc;
                if (stim_ber[n]) m_hb = 1;
            end
        end
        m_pass = (m_err <= THR) && !m_hb;
    endtask

    task automatic applyStimulus(input int exp_done, input int n_edges);
        obs_rst_cnt = 0; obs_en_cnt = 0; obs_done_edge = -1;
        for (int n = 0; n < n_edges; n++) begin
            @(negedge clk_tb);
            link.start          = (n == 0) || (use_noise && n <= exp_done && $urandom_range(0, 3) == 0);
            link.abort          = 1'b0;
            link.rx_block_lock  = stim_lock[n];
            link.rx_error_count = stim_err[n];
            link.rx_high_ber    = stim_ber[n];
            @(posedge clk_tb);
            #1;
            if (link.phy_rst) obs_rst_cnt++;
            if (link.cfg_tx_prbs31_enable && link.cfg_rx_prbs31_enable) obs_en_cnt++;
            if (link.done && obs_done_edge < 0) obs_done_edge = n;
        end
    endtask

    task automatic test_reset();
        rst_n_tb = 1'b0;
        link.start = 0; link.abort = 0; link.rx_block_lock = 0; link.rx_high_ber = 0; link.rx_error_count = 0;
        repeat (2) @(posedge clk_tb);
        #1;
        checks++; if (outs !== '0) begin errors++; $display("[TB] FAIL reset_outputs: got %h expected 0", outs); end
        @(negedge clk_tb) rst_n_tb = 1'b1;
        @(posedge clk_tb);
        #1;
        checks++; if (outs !== '0) begin errors++; $display("[TB] FAIL idle_outputs: got %h expected 0", outs); end
    endtask

    task automatic test_saturation();
        use_noise = 0;
        fill_stim(R + 2, -1, 2, 0);
        model_outcome();
        applyStimulus(m_done, m_done + 3);
        checks++; if (link.err_total !== W'(MAXV)) begin errors++; $display("[TB] FAIL sat_err_total: got %0d expected %0d", link.err_total, MAXV); end
        checks++; if ({link.done, link.pass, link.block_total} !== {1'b1, 1'b0, W'(B)}) begin
            errors++; $display("[TB] FAIL sat_status: got done=%b pass=%b blk=%0d expected 1 0 %0d", link.done, link.pass, link.block_total, B); end
    endtask

    task automatic test_clean_pass();
        use_noise = 0;
        fill_stim(R + 20, -1, 0, 0);
        model_outcome();
        applyStimulus(m_done, m_done + 3);
        checks++; if (obs_rst_cnt !== R) begin errors++; $display("[TB] FAIL clean_phy_rst_cycles: got %0d expected %0d", obs_rst_cnt, R); end
        checks++; if (obs_done_edge !== R + 20 + S + B) begin errors++; $display("[TB] FAIL clean_done_edge: got %0d expected %0d", obs_done_edge, R + 20 + S + B); end
        checks++; if ({link.done, link.pass, link.lock_timeout, link.high_ber_seen} !== 4'b1100) begin
            errors++; $display("[TB] FAIL clean_flags: got %b expected 1100", {link.done, link.pass, link.lock_timeout, link.high_ber_seen}); end
        checks++; if (link.err_total !== W'(0) || link.block_total !== W'(B)) begin
            errors++; $display("[TB] FAIL clean_counters: got err=%0d blk=%0d expected 0 %0d", link.err_total, link.block_total, B); end
        checks++; if (link.cfg_tx_prbs31_enable || link.cfg_rx_prbs31_enable || link.phy_rst) begin
            errors++; $display("[TB] FAIL clean_done_drive: got en=%b%b rst=%b expected 000", link.cfg_tx_prbs31_enable, link.cfg_rx_prbs31_enable, link.phy_rst); end
    endtask

    task automatic test_threshold();
        int n0;
        use_noise = 0;
        n0 = R + 1 + int'($urandom_range(0, 5));
        fill_stim(n0, -1, 0, 0);
        stim_err[n0 + S + 2] = 7'd3;
        stim_err[n0 + S + 7] = 7'd3;
        model_outcome();
        applyStimulus(m_done, m_done + 3);
        checks++; if (link.err_total !== W'(6)) begin errors++; $display("[TB] FAIL thresh_err_total: got %0d expected 6", link.err_total); end
        checks++; if ({link.done, link.pass} !== 2'b10) begin errors++; $display("[TB] FAIL thresh_verdict: got done=%b pass=%b expected 1 0", link.done, link.pass); end
        checks++; if (obs_done_edge !== n0 + S + B) begin errors++; $display("[TB] FAIL thresh_done_edge: got %0d expected %0d", obs_done_edge, n0 + S + B); end
    endtask

    task automatic test_lock_timeout();
        use_noise = 1;
        fill_stim(-1, -1, 1, 30);
        model_outcome();
        applyStimulus(m_done, m_done + 3);
        checks++; if (obs_done_edge !== R + T) begin errors++; $display("[TB] FAIL timeout_done_edge: got %0d expected %0d", obs_done_edge, R + T); end
        checks++; if ({link.done, link.pass, link.lock_timeout, link.high_ber_seen} !== 4'b1010) begin
            errors++; $display("[TB] FAIL timeout_flags: got %b expected 1010", {link.done, link.pass, link.lock_timeout, link.high_ber_seen}); end
        checks++; if (link.block_total !== W'(0) || link.err_total !== W'(0)) begin
            errors++; $display("[TB] FAIL timeout_counters: got err=%0d blk=%0d expected 0 0", link.err_total, link.block_total); end
    endtask

    task automatic test_lock_wins();
        use_noise = 0;
        fill_stim(R + T, -1, 0, 0);
        model_outcome();
        applyStimulus(m_done, m_done + 3);
        checks++; if ({link.done, link.pass, link.lock_timeout} !== 3'b110) begin
            errors++; $display("[TB] FAIL lockwins_flags: got %b expected 110", {link.done, link.pass, link.lock_timeout}); end
        checks++; if (obs_done_edge !== R + T + S + B) begin errors++; $display("[TB] FAIL lockwins_done_edge: got %0d expected %0d", obs_done_edge, R + T + S + B); end
    endtask

    task automatic test_lock_drop();
        use_noise = 0;
        fill_stim(R + 5, R + 5 + S + 5, 0, 0);
        model_outcome();
        applyStimulus(m_done, m_done + 3);
        checks++; if (obs_done_edge !== m_done) begin errors++; $display("[TB] FAIL drop_done_edge: got %0d expected %0d", obs_done_edge, m_done); end
        checks++; if ({link.done, link.pass, link.lock_timeout, link.block_total} !== {1'b1, m_pass, m_lto, W'(m_blk)}) begin
            errors++; $display("[TB] FAIL drop_status: got pass=%b lto=%b blk=%0d expected %b %b %0d", link.pass, link.lock_timeout, link.block_total, m_pass, m_lto, m_blk); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            use_noise = 1;
            fill_stim(int'($urandom_range(1, R + T + 3)), -1, 1, ($urandom_range(0, 1) == 1) ? 3 : 0);
            model_outcome();
            applyStimulus(m_done, m_done + 3);
            checks++; if (obs_done_edge !== m_done || obs_en_cnt !== m_done) begin
                errors++; $display("[TB] FAIL rand_timing[%0d]: got done_edge=%0d en_cycles=%0d expected %0d", it, obs_done_edge, obs_en_cnt, m_done); end
            checks++; if ({link.done, link.pass, link.lock_timeout, link.high_ber_seen} !== {1'b1, m_pass, m_lto, m_hb}) begin
                errors++; $display("[TB] FAIL rand_flags[%0d]: got %b expected %b", it, {link.done, link.pass, link.lock_timeout, link.high_ber_seen}, {1'b1, m_pass, m_lto, m_hb}); end
            checks++; if (link.err_total !== W'(m_err) || link.block_total !== W'(m_blk)) begin
                errors++; $display("[TB] FAIL rand_counters[%0d]: got err=%0d blk=%0d expected %0d %0d", it, link.err_total, link.block_total, m_err, m_blk); end
        end
    endtask

    task automatic test_abort();
        int n0, exp_err;
        use_noise = 0;
        n0 = R + 3;
        fill_stim(n0, -1, 1, 0);
        applyStimulus(n0 + S + 4, n0 + S + 4);
        exp_err = 0;
        for (int n = n0 + S + 1; n <= n0 + S + 3; n++) exp_err += int'(stim_err[n]);
        @(negedge clk_tb);
        link.start = 1'b1; link.abort = 1'b1;
        @(posedge clk_tb);
        #1;
        checks++; if (outs[7+2*W:2*W+2] !== 6'b0) begin errors++; $display("[TB] FAIL abort_outputs: got %b expected 000000", outs[7+2*W:2*W+2]); end
        checks++; if (link.err_total !== W'(exp_err) || link.block_total !== W'(3)) begin
            errors++; $display("[TB] FAIL abort_hold: got err=%0d blk=%0d expected %0d 3", link.err_total, link.block_total, exp_err); end
        @(negedge clk_tb);
        link.start = 1'b0; link.abort = 1'b0;
        @(posedge clk_tb);
        #1;
        checks++; if (link.busy !== 1'b0 || link.block_total !== W'(3)) begin
            errors++; $display("[TB] FAIL abort_idle: got busy=%b blk=%0d expected 0 3", link.busy, link.block_total); end
        @(negedge clk_tb) link.start = 1'b1;
        @(posedge clk_tb);
        #1;
        checks++; if ({link.phy_rst, link.busy, link.err_total, link.block_total} !== {2'b11, W'(0), W'(0)}) begin
            errors++; $display("[TB] FAIL abort_restart: got rst=%b busy=%b err=%0d blk=%0d expected 1 1 0 0", link.phy_rst, link.busy, link.err_total, link.block_total); end
        @(negedge clk_tb);
        link.start = 1'b0; link.abort = 1'b1;
        @(posedge clk_tb);
        #1;
        checks++; if (link.phy_rst !== 1'b0 || link.busy !== 1'b0) begin
            errors++; $display("[TB] FAIL abort_from_reset: got rst=%b busy=%b expected 0 0", link.phy_rst, link.busy); end
        @(negedge clk_tb) link.abort = 1'b0;
    endtask

    task automatic test_async_reset();
        use_noise = 0;
        fill_stim(R + 1, -1, 2, 0);
        applyStimulus(R + 1 + S + 3, R + 1 + S + 3);
        checks++; if (link.block_total !== W'(2)) begin errors++; $display("[TB] FAIL midrun_blocks: got %0d expected 2", link.block_total); end
        @(negedge clk_tb);
        rst_n_tb = 1'b0;
        link.start = 1'b0;
        #1;
        checks++; if (outs !== '0) begin errors++; $display("[TB] FAIL async_reset: got %h expected 0", outs); end
        @(negedge clk_tb) rst_n_tb = 1'b1;
        @(posedge clk_tb);
        #1;
        checks++; if (link.busy !== 1'b0 || link.phy_rst !== 1'b0) begin
            errors++; $display("[TB] FAIL post_reset_idle: got busy=%b rst=%b expected 0 0", link.busy, link.phy_rst); end
    endtask

    initial begin
        test_reset();
        test_saturation();
        test_clean_pass();
        test_threshold();
        test_lock_timeout();
        test_lock_wins();
        test_lock_drop();
        test_random();
        test_abort();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
